multiword_adder_seq_v: RTL and testbench
========================================

Name: multiword_adder_seq_v

Overview:
- Sequencer that performs a wide (W*N-bit) addition by reusing one W-bit carry adder (c_in, x_0, x_1 -> y, c_out) over N cycles, least significant chunk first.
- Carry is chained through a register.
- Operand intake uses a valid/ready handshake; the result is held under a valid/ready handshake.
- Sits between an operand producer and a result consumer where a full-width adder is too costly.

Parameters:
- W, 8, chunk width = width of the shared adder datapath.
- N, 4, number of chunks; operand/result width is W*N; N >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- a  input  W*N  operand A
- b  input  W*N  operand B
- c_in  input  1  carry into chunk 0
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W*N  result
- c_out  output  1  carry out of chunk N-1
- busy  output  1  high in CALC or DONE

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, cnt=0, carry reg=0, sum=0, c_out=0, out_valid=0. in_ready=1 and busy=0 as derived from IDLE.
- Derived outputs: in_ready = (state==IDLE) and out_valid = (state==DONE), both decoded from registered state only. No combinational path from in_valid/out_ready.
- IDLE: on in_valid&in_ready (accept edge):
  - latch a, b into shift registers a_sh, b_sh;
  - carry reg <= c_in;
  - cnt <= 0;
  - state -> CALC.
  - in_valid with no accept has no effect.
- CALC, each edge:
  - adder inputs: x_0=a_sh[W-1:0], x_1=b_sh[W-1:0], c_in=carry reg.
  - sum <= {y, sum[W*N-1:W]}, i.e. the chunk enters at the top and previous chunks shift down.
  - a_sh and b_sh shift right by W; carry reg <= adder c_out; cnt++.
  - When cnt==N-1 on this edge, the final chunk is written: c_out <= adder c_out and state -> DONE.
- DONE:
  - sum and c_out are held stable; operand inputs are ignored.
  - On out_ready=1, state -> IDLE. There is no same-cycle re-accept.
- Latency and throughput:
  - out_valid rises exactly N cycles after the accept edge.
  - Throughput is one operation per N+2 cycles with out_ready held high.
- Arithmetic: {c_out,sum} = a + b + c_in modulo 2^(W*N+1). Wrap-around of sum with carry into c_out is exact.
- Intermediate values:
  - sum during CALC is a partial value; the consumer samples it only when out_valid=1.
  - After reset, sum holds 0 until the first operation completes.
- Reset mid-operation: rst has priority over all transitions in any state.
  - Next cycle: IDLE, out_valid=0, sum=0, c_out=0.
  - The partial result is discarded.
- cnt width: clog2(N), minimum 1 bit.

Optional Feature:
- Macro: MULTIWORD_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched on the accept edge.
  - When sub=1: b_sh loads ~b and the carry reg loads 1 (c_in ignored), so sum = a - b modulo 2^(W*N), and c_out = 1 means no borrow.
  - When sub=0: behaviour is identical to the base block.
- Undefined: the sub port is absent; the block is addition only.

Test Plan (W=8, N=4):
- Basic add: accept a=0x000000FF, b=0x00000001, c_in=0 -> out_valid exactly 4 cycles after accept; sum=0x00000100, c_out=0.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000000, c_in=1 -> sum=0x00000000, c_out=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, toggling in_valid with new operands -> out_valid=1, sum/c_out unchanged, in_ready=0, no new op accepted. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-CALC: assert rst for 1 cycle at cnt=2 -> next cycle out_valid=0, in_ready=1, busy=0, sum=0. A following add of 0x12345678+0x11111111 gives sum=0x23456789, c_out=0.
- Back-to-back: in_valid and out_ready held 1 over two ops -> second accept occurs exactly 1 cycle after first DONE ends; period 6 cycles; both results correct.
- MULTIWORD_ADDER_SUB_EN:
  - sub=1, a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, c_out=0.
  - sub=1, a=7, b=5 -> sum=0x00000002, c_out=1.

Source files
------------

// File: rtl/multiword_adder_seq_v.sv
// Wide adder that reuses one W-bit carry adder over N cycles, LS chunk first.
// Optional subtract mode (sub port) enabled by defining MULTIWORD_ADDER_SUB_EN.

module multiword_adder_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x_0,
    input  logic [W-1:0] x_1,
    input  logic         c_in,
    output logic [W-1:0] y,
    output logic         c_out
);
    assign {c_out, y} = {1'b0, x_0} + {1'b0, x_1} + {{W{1'b0}}, c_in};
endmodule

module multiword_adder_seq_v #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W*N-1:0] a,
    input  logic [W*N-1:0] b,
    input  logic           c_in,
`ifdef MULTIWORD_ADDER_SUB_EN
    input  logic           sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W*N-1:0] sum,
    output logic           c_out,
    output logic           busy
);
    localparam int WN = W * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic          carry;
    logic [WN-1:0] a_sh, b_sh, sum_q;
    logic          c_out_q;
    logic [W-1:0]  y;
    logic          co;

    multiword_adder_chunk #(.W(W)) u_chunk (
        .x_0   (a_sh[W-1:0]),
        .x_1   (b_sh[W-1:0]),
        .c_in  (carry),
        .y     (y),
        .c_out (co)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)       state_d = CALC;
            CALC:    if (cnt == CNT_LAST) state_d = DONE;
            DONE:    if (out_ready)      state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            carry   <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_sh <= a;
`ifdef MULTIWORD_ADDER_SUB_EN
                    // subtract as a + ~b + 1
                    b_sh  <= sub ? ~b : b;
                    carry <= sub ? 1'b1 : c_in;
`else
                    b_sh  <= b;
                    carry <= c_in;
`endif
                    cnt  <= '0;
                end
                CALC: begin
                    // new chunk enters at the top; after N steps chunk 0 sits at the bottom
                    sum_q <= {y, sum_q[WN-1:W]};
                    a_sh  <= a_sh >> W;
                    b_sh  <= b_sh >> W;
                    carry <= co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CNT_LAST) c_out_q <= co;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
endmodule

// File: tb/tb_multiword_adder_seq_v.sv
// Directed bench for multiword_adder_seq_v with a result scoreboard queue.
module tb_multiword_adder_seq_v;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int WN = W * N;

    typedef struct packed {
        logic [WN-1:0] s;
        logic          c;
    } res_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, c_in, sub;
    logic [WN-1:0] a, b;
    logic          in_ready, out_valid, c_out, busy;
    logic [WN-1:0] sum;

    int   checks = 0;
    int   failures = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    multiword_adder_seq_v #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef MULTIWORD_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [WN-1:0] x, input logic [WN-1:0] y,
                                   input logic ci, input logic sb_sub);
        logic [WN:0] t;
        if (sb_sub) t = {1'b0, x} - {1'b0, y};
        else        t = {1'b0, x} + {1'b0, y} + {{WN{1'b0}}, ci};
        model.s = t[WN-1:0];
        // for subtract, c_out=1 means no borrow
        model.c = sb_sub ? (x >= y) : t[WN];
    endfunction

    task automatic start_op(input logic [WN-1:0] x, input logic [WN-1:0] y,
                            input logic ci, input logic s);
        check("in_ready_before_accept", in_ready, 1);
        a = x; b = y; c_in = ci; sub = s; in_valid = 1'b1;
        sb.push_back(model(x, y, ci, s));
        tick();
        in_valid = 1'b0;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic wait_done(input string tag, output res_t e);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, N);
        check({tag, "_sb_size"}, sb.size(), 1);
        e = sb.pop_front();
        check({tag, "_sum"}, sum, e.s);
        check({tag, "_cout"}, c_out, e.c);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, in_ready, 1);
        check({tag, "_idle_out_valid"}, out_valid, 0);
    endtask

    task automatic run_op(input string tag, input logic [WN-1:0] x, input logic [WN-1:0] y,
                          input logic ci, input logic s);
        res_t e;
        start_op(x, y, ci, s);
        wait_done(tag, e);
        release_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        res_t e;
        int   edge_cnt;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = 1'b0; sub = 1'b0;
        a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", c_out, 0);

        run_op("basic", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("wrap", 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b0);

        // backpressure: result must stay put while new operands are offered
        start_op(32'hDEAD_BEEF, 32'h0101_0101, 1'b1, 1'b0);
        wait_done("bp", e);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = $urandom; b = $urandom; c_in = i[0];
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum_held", sum, e.s);
            check("bp_cout_held", c_out, e.c);
        end
        in_valid = 1'b0;
        release_result("bp");

        // reset at cnt==2: partial result discarded
        start_op(32'hAAAA_5555, 32'h1234_5678, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", c_out, 0);
        run_op("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);

        // back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        a = 32'h0F0F_0F0F; b = 32'hF0F0_F0F1; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        sb.push_back(model(a, b, c_in, 1'b0));
        tick();
        edge_cnt = 0;
        while (!out_valid && edge_cnt < 20) begin
            tick();
            edge_cnt++;
        end
        check("b2b1_latency", edge_cnt, N);
        e = sb.pop_front();
        check("b2b1_sum", sum, e.s);
        check("b2b1_cout", c_out, e.c);
        a = 32'h7654_3210; b = 32'h0123_4567; c_in = 1'b1;
        sb.push_back(model(a, b, c_in, 1'b0));
        tick(); edge_cnt++;
        check("b2b_idle_gap", in_ready, 1);
        tick(); edge_cnt++;
        in_valid = 1'b0;
        check("b2b2_accepted", busy, 1);
        check("b2b_period", edge_cnt, N + 2);
        wait_done("b2b2", e);
        tick();
        out_ready = 1'b0;
        check("b2b_end_idle", in_ready, 1);

        for (int i = 0; i < 4; i++) begin
            logic [WN-1:0] ra, rb;
            ra = $urandom; rb = $urandom;
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef MULTIWORD_ADDER_SUB_EN
        run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        run_op("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        run_op("sub_off", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
